// File: rtl/nvram_pkg.sv
// Shared constants and state encoding for the hiscore nvram load/upload path.
package nvram_pkg;

  // Defaults shared with the nvram loader so both sides agree on the dump layout.
  localparam int unsigned DEFAULT_DUMPWIDTH = 6;
  localparam int unsigned DEFAULT_DUMPINDEX = 4;
  localparam int unsigned DEFAULT_PAUSEPAD  = 2;
  localparam int unsigned SUM_WIDTH         = 16;

  typedef enum logic [2:0] {
    StIdle,
    StWaitPause,
    StPad,
    StScan,
    StFlush,
    StDecide,
    StServe
  } nvram_state_e;

endpackage

// File: rtl/nvram_sum.sv
// Byte checksum accumulator. A byte is issued (address presented) one cycle and
// its data is added the next, matching the one-cycle RAM read latency.
module nvram_sum #(
  parameter int unsigned SumWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic                issue_i,
  input  logic [7:0]          data_i,
  output logic [SumWidth-1:0] sum_o,
  output logic [SumWidth-1:0] sum_next_o
);

  logic [SumWidth-1:0] sum_q;
  logic                pending_q;

  // Add the byte whose address was issued last cycle, wrapping mod 2^SumWidth.
  always_comb begin
    sum_next_o = sum_q;
    if (pending_q) begin
      sum_next_o = sum_q + SumWidth'(data_i);
    end
  end

  // Clear drops any in-flight byte so the first cycle after it never adds.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sum_q     <= '0;
      pending_q <= 1'b0;
    end else if (clr_i) begin
      sum_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      sum_q     <= sum_next_o;
      pending_q <= issue_i;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/nvram_upload.sv
// Reads the hiscore dump back to the HPS over ioctl upload, and on OSD open
// checksums the dump to request an upload only when the contents changed.
module nvram_upload
  import nvram_pkg::*;
#(
  parameter int unsigned DUMPWIDTH = DEFAULT_DUMPWIDTH,
  parameter int unsigned DUMPINDEX = DEFAULT_DUMPINDEX,
  parameter int unsigned PAUSEPAD  = DEFAULT_PAUSEPAD,
  parameter int unsigned SUMWIDTH  = SUM_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 autosave,
  input  logic                 OSD_STATUS,
  input  logic                 ioctl_upload,
  input  logic [7:0]           ioctl_index,
  input  logic [24:0]          ioctl_addr,
  input  logic                 ioctl_rd,
  output logic [7:0]           ioctl_din,
  output logic                 ioctl_upload_req,
  output logic [DUMPWIDTH-1:0] nvram_address,
  input  logic [7:0]           nvram_data_out,
  input  logic                 paused,
  output logic                 pause_cpu,
  output logic                 busy
);

  localparam int unsigned DumpBytes = 2 ** DUMPWIDTH;
  localparam logic [DUMPWIDTH-1:0] LastAddr = '1;

  nvram_state_e          state_q, state_d;
  logic                  osd_q;
  logic [7:0]            pad_cnt_q, pad_cnt_d;
  logic [DUMPWIDTH-1:0]  scan_addr_q, scan_addr_d;
  logic [SUMWIDTH-1:0]   last_sum_q, last_sum_d;
  logic                  last_valid_q, last_valid_d;
  logic [DumpBytes-1:0]  seen_q, seen_d;
  logic                  din_ok_q;

  logic                  upload_sel;
  logic                  osd_rise;
  logic                  addr_in_range;
  logic                  enter_serve;
  logic                  sum_clr;
  logic                  sum_issue;
  logic [SUMWIDTH-1:0]   sum;
  logic [SUMWIDTH-1:0]   sum_next;
  logic                  unused_rd;

  // The read strobe carries no handshake meaning here.
  assign unused_rd = ioctl_rd;

  assign upload_sel    = ioctl_upload & (ioctl_index == 8'(DUMPINDEX));
  assign osd_rise      = OSD_STATUS & ~osd_q;
  assign addr_in_range = (ioctl_addr[24:DUMPWIDTH] == '0);
  // An HPS upload pre-empts idle and any unfinished check.
  assign enter_serve   = upload_sel &
                         (state_q inside {StIdle, StWaitPause, StPad, StScan, StFlush});

  nvram_sum #(
    .SumWidth (SUMWIDTH)
  ) u_sum (
    .clk_i      (clk),
    .rst_i      (reset),
    .clr_i      (sum_clr),
    .issue_i    (sum_issue),
    .data_i     (nvram_data_out),
    .sum_o      (sum),
    .sum_next_o (sum_next)
  );

  // Next-state and output decode.
  always_comb begin
    state_d          = state_q;
    pad_cnt_d        = pad_cnt_q;
    scan_addr_d      = scan_addr_q;
    last_sum_d       = last_sum_q;
    last_valid_d     = last_valid_q;
    seen_d           = seen_q;
    sum_clr          = 1'b0;
    sum_issue        = 1'b0;
    pause_cpu        = 1'b0;
    ioctl_upload_req = 1'b0;
    nvram_address    = '0;
    ioctl_din        = 8'h00;
    busy             = (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        if (!upload_sel && osd_rise && autosave) begin
          state_d = StWaitPause;
        end
      end
      StWaitPause: begin
        pause_cpu = 1'b1;
        if (paused) begin
          pad_cnt_d = 8'(PAUSEPAD);
          state_d   = StPad;
        end
      end
      StPad: begin
        pause_cpu = 1'b1;
        if (pad_cnt_q == 8'd0) begin
          scan_addr_d = '0;
          sum_clr     = 1'b1;
          state_d     = StScan;
        end else begin
          pad_cnt_d = pad_cnt_q - 8'd1;
        end
      end
      StScan: begin
        pause_cpu     = 1'b1;
        nvram_address = scan_addr_q;
        sum_issue     = 1'b1;
        scan_addr_d   = scan_addr_q + 1'b1;
        if (scan_addr_q == LastAddr) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        pause_cpu = 1'b1;
        state_d   = StDecide;
      end
      StDecide: begin
        pause_cpu        = 1'b1;
        ioctl_upload_req = !last_valid_q || (sum != last_sum_q);
        state_d          = StIdle;
      end
      StServe: begin
        pause_cpu     = 1'b1;
        nvram_address = ioctl_addr[DUMPWIDTH-1:0];
        ioctl_din     = din_ok_q ? nvram_data_out : 8'h00;
        if (upload_sel) begin
          // Seen-address shadow: each byte joins the sum once however the HPS walks it.
          if (addr_in_range && !seen_q[ioctl_addr[DUMPWIDTH-1:0]]) begin
            sum_issue                         = 1'b1;
            seen_d[ioctl_addr[DUMPWIDTH-1:0]] = 1'b1;
          end
        end else begin
          // sum_next folds in the byte still in flight from last cycle.
          last_valid_d = &seen_q;
          if (&seen_q) begin
            last_sum_d = sum_next;
          end
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (enter_serve) begin
      state_d   = StServe;
      sum_clr   = 1'b1;
      sum_issue = 1'b0;
      seen_d    = '0;
    end
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      osd_q        <= 1'b0;
      pad_cnt_q    <= '0;
      scan_addr_q  <= '0;
      last_sum_q   <= '0;
      last_valid_q <= 1'b0;
      seen_q       <= '0;
      din_ok_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      osd_q        <= OSD_STATUS;
      pad_cnt_q    <= pad_cnt_d;
      scan_addr_q  <= scan_addr_d;
      last_sum_q   <= last_sum_d;
      last_valid_q <= last_valid_d;
      seen_q       <= seen_d;
      // Data returning next cycle belongs to this address; gate out-of-range reads.
      din_ok_q     <= (state_q == StServe) && addr_in_range;
    end
  end

endmodule
